imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 512: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 0: byte address of the first loaded word.
REQ-003 Clocking is fixed as one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 arst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  single-cycle request to begin a load.
REQ-007 abort  in  1  stop any activity and return to IDLE.
REQ-008 word_count  in  16  number of words to load, sampled on accepted start.
REQ-009 s_valid  in  1  stream byte valid.
REQ-010 s_data  in  8  stream byte; bytes arrive little-endian within each word.
REQ-011 s_ready  out  1  loader accepts the byte this cycle.
REQ-012 addr_ext  out  64  byte address to the instruction-memory external port.
REQ-013 wen_ext  out  1  external write strobe.
REQ-014 ren_ext  out  1  external read strobe.
REQ-015 wdata_ext  out  32  external write word.
REQ-016 rdata_ext  in  32  external read word, valid the cycle after ren_ext.
REQ-017 cpu_enable  out  1  drives the processor enable input.
REQ-018 busy, done, error  out  1 each  status flags.
REQ-019 err_addr  out  64  byte address of the first verify mismatch.

Function
REQ-020 States SHALL be IDLE, COLLECT, WRITE, READ, CHECK, RUN, ERROR.
REQ-021 IDLE: on start=1 with word_count=0 -> RUN; with word_count>MAX_WORDS -> ERROR, err_addr=BASE_ADDR; else -> COLLECT, address=BASE_ADDR, words_left=word_count.
REQ-022 start SHALL be ignored in COLLECT, WRITE, READ, CHECK; honoured in IDLE, RUN, ERROR (RUN/ERROR: cpu_enable/error clear in the same cycle the new load begins).
REQ-023 COLLECT: s_ready=1; byte transfer when s_valid&&s_ready; byte n (0..3) SHALL land in word bits [8n+7:8n]; after 4th byte -> WRITE.
REQ-024 s_ready SHALL be 0 in every state except COLLECT.
REQ-025 WRITE: wen_ext=1, addr_ext=current address, wdata_ext=assembled word, exactly one cycle -> READ.
REQ-026 READ: ren_ext=1, same addr_ext, one cycle -> CHECK.
REQ-027 CHECK: compare rdata_ext with assembled word; mismatch -> ERROR, err_addr=current address; match and words_left=1 -> RUN; match otherwise -> COLLECT, address+=4, words_left-=1.
REQ-028 wen_ext and ren_ext SHALL never be 1 simultaneously; both 0 outside WRITE/READ.
REQ-029 addr_ext SHALL hold the current address in all states and BASE_ADDR in IDLE; 64-bit addition wraps modulo 2^64.
REQ-030 Minimum per-word latency at full stream rate SHALL be 7 cycles (4 collect, write, read, check).
REQ-031 RUN: cpu_enable=1, done=1, busy=0; remains until abort, reset or accepted start.
REQ-032 ERROR: error=1, cpu_enable=0, err_addr held until next accepted start, abort or reset.
REQ-033 busy SHALL be 1 exactly in COLLECT, WRITE, READ, CHECK.
REQ-034 abort=1 in any state SHALL go to IDLE next cycle, clear cpu_enable, done, error, byte index; abort has priority over start and stream bytes in the same cycle.
REQ-035 A partial word in COLLECT at abort/reset SHALL be discarded; no write issued.

Reset
REQ-036 arst_n=0 sampled on a clock edge SHALL force IDLE, s_ready=0, wen_ext=0, ren_ext=0, cpu_enable=0, busy=0, done=0, error=0, addr_ext=BASE_ADDR, wdata_ext=0, err_addr=0, byte index 0.
REQ-037 Reset SHALL take effect mid-operation including during WRITE/READ; no output changes between edges.

Verification
REQ-038 start, word_count=2, bytes 13 00 00 00 93 00 10 00 continuous, memory model echoes -> writes 0x00000013 @0, 0x00100093 @4, RUN 14 cycles after first byte, cpu_enable=1.
REQ-039 word_count=1, s_valid toggled every other cycle -> s_ready only in COLLECT, word assembled correctly, no extra bytes consumed.
REQ-040 word_count=3, model corrupts read at 0x8 -> ERROR, err_addr=0x8, cpu_enable=0, no write to 0xC.
REQ-041 word_count=0 -> RUN next cycle, no strobes; word_count=513 -> ERROR, err_addr=0.
REQ-042 arst_n=0 during WRITE of word 1, then new start with word_count=1 -> all outputs reset values, fresh load writes address 0.
REQ-043 abort and start same cycle in RUN -> IDLE, cpu_enable=0, start ignored.

Source files
------------

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words, writes each to instruction memory, reads it back to verify,
// then enables the CPU. All outputs are decoded from registered state only.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 512,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] word_count,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] err_addr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] left_q, left_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [63:0] err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = err_q;
    // abort outranks start and any byte offered in the same cycle
    if (abort) begin
      state_d = IDLE;
      addr_d  = BASE_ADDR;
      word_d  = 32'd0;
      idx_d   = 2'd0;
      err_d   = 64'd0;
    end else begin
      case (state_q)
        IDLE, RUN, ERROR: begin
          if (start) begin
            err_d  = 64'd0;
            idx_d  = 2'd0;
            addr_d = BASE_ADDR;
            if (word_count == 16'd0) begin
              state_d = RUN;
            end else if (32'(word_count) > MAX_WORDS) begin
              state_d = ERROR;
              err_d   = BASE_ADDR;
            end else begin
              state_d = COLLECT;
              left_d  = word_count;
            end
          end
        end
        COLLECT: begin
          if (s_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = s_data;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = WRITE;
          end
        end
        WRITE: state_d = READ;
        READ:  state_d = CHECK;
        CHECK: begin
          if (rdata_ext != word_q) begin
            state_d = ERROR;
            err_d   = addr_q;
          end else if (left_q == 16'd1) begin
            state_d = RUN;
          end else begin
            state_d = COLLECT;
            addr_d  = addr_q + 64'd4;
            left_d  = left_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      left_q  <= 16'd0;
      word_q  <= 32'd0;
      idx_q   <= 2'd0;
      err_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign s_ready    = (state_q == COLLECT);
  assign wen_ext    = (state_q == WRITE);
  assign ren_ext    = (state_q == READ);
  assign addr_ext   = addr_q;
  assign wdata_ext  = word_q;
  assign cpu_enable = (state_q == RUN);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERROR);
  assign busy       = (state_q == COLLECT) || (state_q == WRITE) ||
                      (state_q == READ) || (state_q == CHECK);
  assign err_addr   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an echoing memory model that can corrupt one read address.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        arst_n, start, abort, s_valid;
  logic [15:0] word_count;
  logic [7:0]  s_data;
  logic        s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
  logic [63:0] addr_ext, err_addr;
  logic [31:0] wdata_ext, rdata_ext;

  imem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .addr_ext(addr_ext),
    .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // memory model: write on wen, registered read data, optional corruption at one address
  logic [31:0] mem [0:15];
  logic [63:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;
  logic        corrupt_en = 1'b0;
  logic [63:0] corrupt_addr = 64'd0;

  always @(posedge clk) begin
    if (wen_ext) begin
      mem[addr_ext[5:2]] <= wdata_ext;
      wr_addr[wr_cnt[5:0]] <= addr_ext;
      wr_data[wr_cnt[5:0]] <= wdata_ext;
      wr_cnt <= wr_cnt + 1;
    end
    if (ren_ext)
      rdata_ext <= mem[addr_ext[5:2]] ^
                   ((corrupt_en && addr_ext == corrupt_addr) ? 32'h0000_0100 : 32'h0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sbytes [0:15];
  int ptr;
  int sready_cycles;
  bit viol;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] wc);
    start = 1'b1;
    word_count = wc;
    step();
    start = 1'b0;
  endtask

  task automatic run_stream(input int nbytes, input bit toggle, input int max_cyc,
                            input bit stop_on_end, output int cyc);
    bit acc;
    cyc = 0;
    ptr = 0;
    sready_cycles = 0;
    viol = 1'b0;
    while (cyc < max_cyc) begin
      if (stop_on_end && (cpu_enable || error)) break;
      s_valid = (ptr < nbytes) && (!toggle || (cyc % 2 == 0));
      s_data  = (ptr < nbytes) ? sbytes[ptr] : 8'h00;
      if (s_ready) sready_cycles++;
      if (s_ready && (!busy || wen_ext || ren_ext)) viol = 1'b1;
      if (wen_ext && ren_ext) viol = 1'b1;
      acc = s_valid && s_ready;
      step();
      if (acc) ptr++;
      cyc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_wen"}, 64'(wen_ext), 64'd0);
    chk({tag, "_ren"}, 64'(ren_ext), 64'd0);
    chk({tag, "_cpu_en"}, 64'(cpu_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_addr"}, addr_ext, 64'd0);
    chk({tag, "_wdata"}, 64'(wdata_ext), 64'd0);
    chk({tag, "_err_addr"}, err_addr, 64'd0);
  endtask

  int cyc, w0;

  initial begin
    arst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    word_count = 16'd0; s_data = 8'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    step(); step();
    check_reset_state("rst");
    arst_n = 1'b1;
    step();

    // two words at full stream rate
    sbytes[0] = 8'h13; sbytes[1] = 8'h00; sbytes[2] = 8'h00; sbytes[3] = 8'h00;
    sbytes[4] = 8'h93; sbytes[5] = 8'h00; sbytes[6] = 8'h10; sbytes[7] = 8'h00;
    w0 = wr_cnt;
    do_start(16'd2);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    run_stream(8, 1'b0, 100, 1'b1, cyc);
    chk("t1_cycles_to_run", 64'(cyc), 64'd14);
    chk("t1_cpu_en", 64'(cpu_enable), 64'd1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_nwrites", 64'(wr_cnt - w0), 64'd2);
    chk("t1_w0_addr", wr_addr[w0], 64'h0);
    chk("t1_w0_data", 64'(wr_data[w0]), 64'h0000_0013);
    chk("t1_w1_addr", wr_addr[w0 + 1], 64'h4);
    chk("t1_w1_data", 64'(wr_data[w0 + 1]), 64'h0010_0093);
    chk("t1_protocol", 64'(viol), 64'd0);

    // one word, bytes offered every other cycle; start honoured from RUN
    sbytes[0] = 8'hEF; sbytes[1] = 8'hBE; sbytes[2] = 8'hAD; sbytes[3] = 8'hDE;
    sbytes[4] = 8'h55; sbytes[5] = 8'h66; sbytes[6] = 8'h77; sbytes[7] = 8'h88;
    w0 = wr_cnt;
    do_start(16'd1);
    chk("t2_cpu_en_cleared", 64'(cpu_enable), 64'd0);
    run_stream(8, 1'b1, 100, 1'b1, cyc);
    chk("t2_cycles_to_run", 64'(cyc), 64'd10);
    chk("t2_bytes_used", 64'(ptr), 64'd4);
    chk("t2_sready_cycles", 64'(sready_cycles), 64'd7);
    chk("t2_nwrites", 64'(wr_cnt - w0), 64'd1);
    chk("t2_w0_data", 64'(wr_data[w0]), 64'hDEAD_BEEF);
    chk("t2_protocol", 64'(viol), 64'd0);
    chk("t2_done", 64'(done), 64'd1);

    // readback of word at 0x8 corrupted
    for (int i = 0; i < 12; i++) sbytes[i] = 8'(8'h21 + i);
    corrupt_en = 1'b1; corrupt_addr = 64'h8;
    w0 = wr_cnt;
    do_start(16'd3);
    run_stream(12, 1'b0, 100, 1'b1, cyc);
    corrupt_en = 1'b0;
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_err_addr", err_addr, 64'h8);
    chk("t3_cpu_en", 64'(cpu_enable), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_nwrites", 64'(wr_cnt - w0), 64'd3);
    chk("t3_last_waddr", wr_addr[w0 + 2], 64'h8);
    chk("t3_w2_data", 64'(wr_data[w0 + 2]), 64'h2C2B_2A29);
    step();
    chk("t3_err_addr_held", err_addr, 64'h8);

    // zero words from ERROR, then oversize count
    w0 = wr_cnt;
    do_start(16'd0);
    chk("t4_zero_run", 64'(cpu_enable), 64'd1);
    chk("t4_zero_err_clr", 64'(error), 64'd0);
    chk("t4_zero_err_addr", err_addr, 64'd0);
    step(); step();
    chk("t4_zero_nowrites", 64'(wr_cnt - w0), 64'd0);
    do_start(16'd513);
    chk("t4_513_error", 64'(error), 64'd1);
    chk("t4_513_err_addr", err_addr, 64'd0);
    chk("t4_513_cpu_en", 64'(cpu_enable), 64'd0);

    // 512 is accepted; abort mid-word drops the partial word
    w0 = wr_cnt;
    do_start(16'd512);
    chk("t5_512_busy", 64'(busy), 64'd1);
    s_valid = 1'b1; s_data = 8'hAA;
    step(); step();
    s_valid = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b0;
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_sready", 64'(s_ready), 64'd0);
    step(); step(); step();
    chk("t5_abort_nowrites", 64'(wr_cnt - w0), 64'd0);

    // reset during WRITE of the second word
    for (int i = 0; i < 8; i++) sbytes[i] = 8'(8'h40 + i);
    do_start(16'd2);
    run_stream(8, 1'b0, 11, 1'b0, cyc);
    chk("t6_in_write", 64'(wen_ext), 64'd1);
    chk("t6_write_addr", addr_ext, 64'h4);
    arst_n = 1'b0;
    step();
    check_reset_state("t6_rst");
    arst_n = 1'b1;
    sbytes[0] = 8'h01; sbytes[1] = 8'h02; sbytes[2] = 8'h03; sbytes[3] = 8'h04;
    w0 = wr_cnt;
    do_start(16'd1);
    run_stream(4, 1'b0, 100, 1'b1, cyc);
    chk("t6_fresh_nwrites", 64'(wr_cnt - w0), 64'd1);
    chk("t6_fresh_addr", wr_addr[w0], 64'h0);
    chk("t6_fresh_data", 64'(wr_data[w0]), 64'h0403_0201);
    chk("t6_fresh_run", 64'(cpu_enable), 64'd1);

    // abort beats start in RUN
    abort = 1'b1; start = 1'b1; word_count = 16'd1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("t7_cpu_en", 64'(cpu_enable), 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_addr", addr_ext, 64'd0);
    step();
    chk("t7_still_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
